// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment types, glyph constants and BCD decode function
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    // Glyphs are {a,b,c,d,e,f,g}, active-high
    localparam seg7_t SEG_0     = 7'h7E;
    localparam seg7_t SEG_1     = 7'h30;
    localparam seg7_t SEG_2     = 7'h6D;
    localparam seg7_t SEG_3     = 7'h79;
    localparam seg7_t SEG_4     = 7'h33;
    localparam seg7_t SEG_5     = 7'h5B;
    localparam seg7_t SEG_6     = 7'h5F;
    localparam seg7_t SEG_7     = 7'h70;
    localparam seg7_t SEG_8     = 7'h7F;
    localparam seg7_t SEG_9     = 7'h7B;
    localparam seg7_t SEG_BLANK = 7'h00;

    function automatic seg7_t bcd_to_seg7(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_seg7_dec.sv
// rtl/bcd_seg7_dec.sv - combinational BCD to 7-segment decoder, non-BCD codes go dark
module bcd_seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    assign seg_o = bcd_to_seg7(bcd_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with tear-free shadow/active digits
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    pending,
    output logic                    frame_done
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACT_LOW}};

    logic [DW-1:0]             div_cnt_q, div_cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_bcd_q, active_bcd_q;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, active_dp_q;
    logic                      pending_q;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     dig_en_q, dig_en_d;
    logic                      frame_done_q;

    logic                      commit;
    phase_e                    phase;
    logic [3:0]                cur_digit;
    logic [6:0]                dec_seg;
    logic [NUM_DIGITS-1:0]     zero_from;
    logic                      zero_run;
    logic                      suppress;

    bcd_seg7_dec u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        commit    = (idx_q == IDX_LAST) && (div_cnt_q == DIV_LAST);
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        phase     = (int'(div_cnt_q) < BLANK_CYC) ? PH_BLANK : PH_SHOW;
        cur_digit = active_bcd_q[{idx_q, 2'b00} +: 4];

        // zero_from[i]: every active digit from i up to the MS digit is zero
        zero_run  = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (active_bcd_q[4*i +: 4] == 4'd0);
            zero_from[i] = zero_run;
        end
        suppress  = lz_en && (idx_q != '0) && zero_from[idx_q];

        seg_d    = SEG_BLANK;
        dp_d     = 1'b0;
        dig_en_d = DIG_OFF;
        if (phase == PH_SHOW) begin
            seg_d    = suppress ? SEG_BLANK : dec_seg;
            dp_d     = active_dp_q[idx_q];
            dig_en_d = ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            active_bcd_q <= '0;
            active_dp_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b0;
            dig_en_q     <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= commit;
            if (load) begin
                shadow_bcd_q <= bcd_in;
                shadow_dp_q  <= dp_in;
            end
            // Active only moves at the frame boundary; a load landing there skips the shadow
            if (commit) begin
                pending_q <= 1'b0;
                if (load) begin
                    active_bcd_q <= bcd_in;
                    active_dp_q  <= dp_in;
                end else if (pending_q) begin
                    active_bcd_q <= shadow_bcd_q;
                    active_dp_q  <= shadow_dp_q;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign dig_en     = dig_en_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
